// File: rtl/point_report_sequencer_if.sv
// -----------------------------------------------------------------------------
// point_report_sequencer_if
//   Byte-wide valid/ready link between the report sequencer and the UART/host
//   side. A byte moves on every clock where tx_valid and tx_ready are both 1.
//
//   tx_data   8  packet byte, held stable while tx_valid & ~tx_ready
//   tx_valid  1  tx_data carries a packet byte
//   tx_ready  1  sink can take the byte this cycle
//
//   master : the sequencer (drives tx_data/tx_valid)
//   slave  : the link sink (drives tx_ready)
// -----------------------------------------------------------------------------
interface point_report_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/point_report_sequencer.sv
// -----------------------------------------------------------------------------
// point_report_sequencer
//   Frame-level controller behind the multi-point finder. Snapshots the
//   finder's centroids once per frame (one cycle after the VGA_VS falling
//   edge), keeps one pending snapshot, and serialises each snapshot as
//     HEADER_BYTE, tag, mask, {H_hi,H_lo,V_hi,V_lo} x NUM_POINTS, sum
//   over a valid/ready byte link. A snapshot overwritten before it could be
//   loaded counts as a dropped frame (saturating counter).
//
//   CLK          in   system/pixel clock, posedge
//   RST          in   asynchronous, active-high reset
//   VGA_VS       in   vertical sync
//   i_ENABLE     in   1 = capture new frames
//   i_POINTS_H   in   point k H at [16k+15:16k]
//   i_POINTS_V   in   point k V at [16k+15:16k]
//   tx           if   byte link, master side
//   o_BUSY       out  packet in progress or snapshot pending
//   o_FRAME_TAG  out  tag of the most recent capture
//   o_DROP_CNT   out  overwritten snapshots, saturating
// -----------------------------------------------------------------------------
module point_report_sequencer #(
  parameter int         NUM_POINTS  = 4,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         DROP_W      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     VGA_VS,
  input  logic                     i_ENABLE,
  input  logic [16*NUM_POINTS-1:0] i_POINTS_H,
  input  logic [16*NUM_POINTS-1:0] i_POINTS_V,
  point_report_sequencer_if.master tx,
  output logic                     o_BUSY,
  output logic [7:0]               o_FRAME_TAG,
  output logic [DROP_W-1:0]        o_DROP_CNT
);
  localparam int         PW       = 16*NUM_POINTS;
  localparam logic [4:0] LAST_IDX = 5'(4*NUM_POINTS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HDR, S_TAG, S_MASK, S_DATA, S_SUM
  } state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // control state (asynchronously reset)
  state_t            state_q, state_d;
  logic              vs_q;
  logic              cap_q;
  logic              pend_q;
  logic [7:0]        tag_cnt_q;
  logic [7:0]        frame_tag_q;
  logic [DROP_W-1:0] drop_q;

  // data state (no reset: always written before it is used)
  logic [PW-1:0]     pend_h_q, pend_v_q;
  logic [7:0]        pend_tag_q;
  logic [PW-1:0]     act_h_q, act_v_q;
  logic [7:0]        act_tag_q;
  logic [7:0]        mask_q, mask_d;
  logic [7:0]        sum_q;
  logic [4:0]        idx_q;

  logic              fall, cap_take, load_now, fire;
  logic [15:0]       cur_h, cur_v;
  logic [7:0]        data_byte;

  assign fall     = vs_q & ~VGA_VS;
  assign cap_take = cap_q & i_ENABLE;
  assign load_now = (state_q == S_LOAD);
  assign fire     = tx.tx_valid & tx.tx_ready;

  assign o_BUSY      = (state_q != S_IDLE) | pend_q;
  assign o_FRAME_TAG = frame_tag_q;
  assign o_DROP_CNT  = drop_q;

  // --- capture strobe / pending buffer -------------------------------------
  // cap is the falling edge delayed one cycle so the finder outputs settle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      cap_q       <= 1'b0;
      pend_q      <= 1'b0;
      tag_cnt_q   <= 8'd0;
      frame_tag_q <= 8'd0;
      drop_q      <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= VGA_VS;
      cap_q   <= fall;
      if (cap_take) begin
        pend_q      <= 1'b1;
        frame_tag_q <= tag_cnt_q;
        tag_cnt_q   <= tag_cnt_q + 8'd1;
        // A capture in the LOAD cycle replaces a buffer that is being
        // consumed, so only an unconsumed pending snapshot is a drop.
        if (pend_q && !load_now)
          drop_q <= sat_inc(drop_q);
      end else if (load_now) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    mask_d = '0;
    for (int k = 0; k < NUM_POINTS; k++)
      mask_d[k] = (pend_h_q[16*k +: 16] != 16'd0) | (pend_v_q[16*k +: 16] != 16'd0);
  end

  // --- active packet registers ---------------------------------------------
  // LOAD reads the pending buffer on the same edge a new capture may
  // overwrite it, so LOAD always takes the older snapshot.
  always_ff @(posedge CLK) begin
    if (cap_take) begin
      pend_h_q   <= i_POINTS_H;
      pend_v_q   <= i_POINTS_V;
      pend_tag_q <= tag_cnt_q;
    end
    if (load_now) begin
      act_h_q   <= pend_h_q;
      act_v_q   <= pend_v_q;
      act_tag_q <= pend_tag_q;
      mask_q    <= mask_d;
      sum_q     <= 8'd0;
      idx_q     <= 5'd0;
    end else if (fire) begin
      sum_q <= sum_q + tx.tx_data;
      if (state_q == S_DATA)
        idx_q <= idx_q + 5'd1;
    end
  end

  // DATA byte: point idx/4, byte idx%4 in order H_hi, H_lo, V_hi, V_lo.
  always_comb begin
    cur_h = 16'd0;
    cur_v = 16'd0;
    for (int k = 0; k < NUM_POINTS; k++) begin
      if (idx_q[4:2] == 3'(k)) begin
        cur_h = act_h_q[16*k +: 16];
        cur_v = act_v_q[16*k +: 16];
      end
    end
    case (idx_q[1:0])
      2'd0:    data_byte = cur_h[15:8];
      2'd1:    data_byte = cur_h[7:0];
      2'd2:    data_byte = cur_v[15:8];
      default: data_byte = cur_v[7:0];
    endcase
  end

  // --- packet FSM: next state and byte port --------------------------------
  // Byte states hold their byte until the handshake, which keeps tx_data
  // stable under backpressure and valid high for the whole packet.
  always_comb begin
    state_d     = state_q;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'd0;
    case (state_q)
      S_IDLE: if (pend_q || cap_take) state_d = S_LOAD;
      S_LOAD: state_d = S_HDR;
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER_BYTE;
        if (tx.tx_ready) state_d = S_TAG;
      end
      S_TAG: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = act_tag_q;
        if (tx.tx_ready) state_d = S_MASK;
      end
      S_MASK: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = mask_q;
        if (tx.tx_ready) state_d = S_DATA;
      end
      S_DATA: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = data_byte;
        if (tx.tx_ready && idx_q == LAST_IDX) state_d = S_SUM;
      end
      S_SUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = sum_q;
        // A capture landing on the final handshake goes straight to LOAD.
        if (tx.tx_ready) state_d = (pend_q || cap_take) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
